// File: rtl/cp0_int_timer.sv
// CP0 Count/Compare/Status/Cause-IP block: interrupt synchronisation, capture and request generation.
// Optional CP0_DBG_FREEZE_EN adds dbg_freeze, which halts the prescaler/Count and blocks TI.
module cp0_int_timer #(
  parameter int unsigned NUM_HW_INT  = 6,
  parameter int unsigned COUNT_DIV   = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [5:0]  EDGE_MASK   = 6'b000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wen,
  input  logic [4:0]            waddr,
  input  logic [31:0]           wdata,
  input  logic [4:0]            raddr,
  output logic [31:0]           rdata,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic                  exc_commit,
  input  logic                  eret,
  output logic                  int_req,
  output logic [2:0]            int_id,
  output logic                  timer_irq
`ifdef CP0_DBG_FREEZE_EN
  ,
  input  logic                  dbg_freeze
`endif
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;

  localparam logic [3:0]            PRESC_MAX = 4'(COUNT_DIV - 1);
  localparam logic [NUM_HW_INT-1:0] EMASK     = EDGE_MASK[NUM_HW_INT-1:0];

  logic freeze;
`ifdef CP0_DBG_FREEZE_EN
  assign freeze = dbg_freeze;
`else
  assign freeze = 1'b0;
`endif

  logic wr_count, wr_compare, wr_status, wr_cause;
  assign wr_count   = wen && (waddr == REG_COUNT);
  assign wr_compare = wen && (waddr == REG_COMPARE);
  assign wr_status  = wen && (waddr == REG_STATUS);
  assign wr_cause   = wen && (waddr == REG_CAUSE);

  logic [SYNC_STAGES-1:0][NUM_HW_INT-1:0] sync_q;
  logic [NUM_HW_INT-1:0] synced, synced_d, rise, w1c, ip_hw;
  logic [3:0]  presc;
  logic [31:0] count, compare, count_next;
  logic [7:0]  im, eff_ip, pend;
  logic [1:0]  ip_sw;
  logic        ie, exl, ti, tick, count_inc;
  logic [2:0]  pend_id;

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~synced_d;
  assign w1c    = wdata[10 +: NUM_HW_INT] & {NUM_HW_INT{wr_cause}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      synced_d <= '0;
      ip_hw    <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], hw_int};
      synced_d <= synced;
      // Level lines track the synchroniser; edge lines are sticky, and a new edge beats a same-cycle W1C.
      ip_hw    <= (~EMASK & synced) | (EMASK & (rise | (ip_hw & ~w1c)));
    end
  end

  assign tick       = (presc == PRESC_MAX);
  assign count_next = count + 32'd1;
  assign count_inc  = tick && !freeze && !wr_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      count <= '0;
    end else if (wr_count) begin
      count <= wdata;
      presc <= '0;
    end else if (!freeze) begin
      if (tick) begin
        presc <= '0;
        count <= count_next;
      end else begin
        presc <= presc + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      compare <= '0;
      ti      <= 1'b0;
      im      <= '0;
      ie      <= 1'b0;
      exl     <= 1'b0;
      ip_sw   <= '0;
    end else begin
      if (wr_compare) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (count_inc && (count_next == compare)) begin
        ti      <= 1'b1;
      end
      if (wr_status) begin
        im <= wdata[15:8];
        ie <= wdata[0];
      end
      if (eret)            exl <= 1'b0;
      else if (exc_commit) exl <= 1'b1;
      else if (wr_status)  exl <= wdata[1];
      if (wr_cause) ip_sw <= wdata[9:8];
    end
  end

  always_comb begin
    eff_ip = '0;
    eff_ip[1:0] = ip_sw;
    eff_ip[2 +: NUM_HW_INT] = ip_hw;
    eff_ip[7] = eff_ip[7] | ti;
  end

  assign pend = eff_ip & im;

  always_comb begin
    pend_id = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (pend[i]) pend_id = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_req <= 1'b0;
      int_id  <= '0;
    end else begin
      int_req <= ie && !exl && (|pend);
      int_id  <= pend_id;
    end
  end

  assign timer_irq = ti;

  always_comb begin
    rdata = '0;
    case (raddr)
      REG_COUNT:   rdata = count;
      REG_COMPARE: rdata = compare;
      REG_STATUS:  rdata = {3'b0, 1'b1, 5'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
      REG_CAUSE:   rdata = {1'b0, ti, 14'b0, eff_ip, 8'b0};
      default:     rdata = '0;
    endcase
  end

endmodule
